// File: rtl/evg_pkg.sv
// Shared constants and helpers for the EVG event path.
// Source indices also fix the bit order of every per-source vector.
package evg_pkg;

  localparam int NUM_SOURCES = 4;

  localparam int SRC_SEQA = 0;
  localparam int SRC_SEQB = 1;
  localparam int SRC_HW   = 2;
  localparam int SRC_SW   = 3;

  localparam int unsigned NULL_EVENT_CODE         = 0;
  localparam logic [7:0]  END_OF_TABLE_EVENT_CODE = 8'h7F;

  typedef logic [NUM_SOURCES-1:0] src_mask_t;

  // Fixed priority hw > seqA > seqB > sw; returns a one-hot grant or zero.
  function automatic src_mask_t priority_grant(input src_mask_t nonempty);
    src_mask_t grant;
    grant = '0;
    if (nonempty[SRC_HW])        grant[SRC_HW]   = 1'b1;
    else if (nonempty[SRC_SEQA]) grant[SRC_SEQA] = 1'b1;
    else if (nonempty[SRC_SEQB]) grant[SRC_SEQB] = 1'b1;
    else if (nonempty[SRC_SW])   grant[SRC_SW]   = 1'b1;
    return grant;
  endfunction

endpackage

// File: rtl/evg_event_fifo.sv
// Single-clock first-word-fall-through FIFO with async active-high reset.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module evg_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] headData
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign w_do_push = push && (!full || pop);
  assign w_do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are
  // valid, so the array maps onto plain RAM without a reset network.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= pushData;
  end

  assign headData = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/evg_event_arbiter.sv
// Merges four event-code producers through per-source FIFOs into one
// TVALID/TREADY output register, with sticky overflow flags and drop counters.
module evg_event_arbiter
  import evg_pkg::*;
#(
  parameter int EVENTCODE_WIDTH    = 8,
  parameter int FIFO_DEPTH         = 8,
  parameter int DROP_COUNTER_WIDTH = 8
) (
  input  logic                          evgTxClk,
  input  logic                          evgTxReset,
  input  logic [EVENTCODE_WIDTH-1:0]    seqAEventTDATA,
  input  logic                          seqAEventTVALID,
  input  logic [EVENTCODE_WIDTH-1:0]    seqBEventTDATA,
  input  logic                          seqBEventTVALID,
  input  logic [EVENTCODE_WIDTH-1:0]    hwEventTDATA,
  input  logic                          hwEventTVALID,
  input  logic [EVENTCODE_WIDTH-1:0]    swEventTDATA,
  input  logic                          swEventTVALID,
  input  logic                          statsClear,
  output logic [EVENTCODE_WIDTH-1:0]    evgEventTDATA,
  output logic                          evgEventTVALID,
  input  logic                          evgEventTREADY,
  output logic [3:0]                    overflowFlags,
  output logic [DROP_COUNTER_WIDTH-1:0] dropCountA,
  output logic [DROP_COUNTER_WIDTH-1:0] dropCountB,
  output logic [DROP_COUNTER_WIDTH-1:0] dropCountHw,
  output logic [DROP_COUNTER_WIDTH-1:0] dropCountSw,
  output logic [3:0]                    fifoNotEmpty
);

  localparam int W  = EVENTCODE_WIDTH;
  localparam int CW = DROP_COUNTER_WIDTH;

  logic [W-1:0] w_req_data [NUM_SOURCES];
  logic [W-1:0] w_head     [NUM_SOURCES];
  src_mask_t    w_req_raw;
  src_mask_t    w_req_valid;
  src_mask_t    w_full;
  src_mask_t    w_empty;
  src_mask_t    w_grant;
  src_mask_t    w_pop;
  src_mask_t    w_push;
  src_mask_t    w_drop;
  logic         w_load;
  logic [W-1:0] w_head_sel;

  logic          r_valid;
  logic [W-1:0]  r_data;
  src_mask_t     r_overflow;
  logic [CW-1:0] r_drop_cnt [NUM_SOURCES];

  assign w_req_data[SRC_SEQA] = seqAEventTDATA;
  assign w_req_data[SRC_SEQB] = seqBEventTDATA;
  assign w_req_data[SRC_HW]   = hwEventTDATA;
  assign w_req_data[SRC_SW]   = swEventTDATA;

  assign w_req_raw[SRC_SEQA] = seqAEventTVALID;
  assign w_req_raw[SRC_SEQB] = seqBEventTVALID;
  assign w_req_raw[SRC_HW]   = hwEventTVALID;
  assign w_req_raw[SRC_SW]   = swEventTVALID;

  assign w_load  = !r_valid || evgEventTREADY;
  assign w_grant = priority_grant(~w_empty);
  assign w_pop   = w_load ? w_grant : '0;

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_src
    // Null codes are treated as no request: never stored, never counted.
    assign w_req_valid[g] = w_req_raw[g] && (w_req_data[g] != W'(NULL_EVENT_CODE));
    assign w_push[g]      = w_req_valid[g] && (!w_full[g] || w_pop[g]);
    assign w_drop[g]      = w_req_valid[g] && !w_push[g];

    evg_event_fifo #(
      .WIDTH (W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (evgTxClk),
      .rst      (evgTxReset),
      .push     (w_push[g]),
      .pushData (w_req_data[g]),
      .pop      (w_pop[g]),
      .full     (w_full[g]),
      .empty    (w_empty[g]),
      .headData (w_head[g])
    );
  end

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_head_sel = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (w_grant[i]) w_head_sel = w_head_sel | w_head[i];
    end
  end

  // TDATA keeps its last code when the register loads from all-empty FIFOs.
  always_ff @(posedge evgTxClk or posedge evgTxReset) begin
    if (evgTxReset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= |w_grant;
      if (|w_grant) r_data <= w_head_sel;
    end
  end

  // A drop on the same edge as statsClear wins and restarts the count at one.
  always_ff @(posedge evgTxClk or posedge evgTxReset) begin
    if (evgTxReset) begin
      r_overflow <= '0;
      for (int i = 0; i < NUM_SOURCES; i++) r_drop_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        if (w_drop[i]) begin
          r_overflow[i] <= 1'b1;
          if (statsClear)         r_drop_cnt[i] <= CW'(1);
          else if (!(&r_drop_cnt[i])) r_drop_cnt[i] <= r_drop_cnt[i] + CW'(1);
        end else if (statsClear) begin
          r_overflow[i] <= 1'b0;
          r_drop_cnt[i] <= '0;
        end
      end
    end
  end

  assign evgEventTVALID = r_valid;
  assign evgEventTDATA  = r_data;
  assign overflowFlags  = r_overflow;
  assign fifoNotEmpty   = ~w_empty;
  assign dropCountA     = r_drop_cnt[SRC_SEQA];
  assign dropCountB     = r_drop_cnt[SRC_SEQB];
  assign dropCountHw    = r_drop_cnt[SRC_HW];
  assign dropCountSw    = r_drop_cnt[SRC_SW];

endmodule
